// File: rtl/font5_pkg.sv
// rtl/font5_pkg.sv - shared constants, types and saturation helpers for the FONT5 feedback datapath
package font5_pkg;

  localparam int ADC_W = 13;
  localparam logic [ADC_W-1:0] MIDSCALE = 13'h1000;

  // Each mask undoes the board's bit-line swaps and also flips the sign bit,
  // so raw ^ mask yields a signed two's-complement sample.
  localparam logic [ADC_W-1:0] CH1_BITFLIP = 13'b1011010000101 ^ 13'h1000;
  localparam logic [ADC_W-1:0] CH2_BITFLIP = 13'b0101110001000 ^ 13'h1000;
  localparam logic [ADC_W-1:0] CH4_BITFLIP = 13'b0111100000000 ^ 13'h1000;
  localparam logic [ADC_W-1:0] CH5_BITFLIP = 13'b0100110011010 ^ 13'h1000;

  // DAC strobe start-up sequence: three flush cycles after reset, then run.
  typedef enum logic [1:0] {
    ST_FLUSH0 = 2'd0,
    ST_FLUSH1 = 2'd1,
    ST_FLUSH2 = 2'd2,
    ST_RUN    = 2'd3
  } strobe_state_e;

  // Clamp a 14-bit signed pair sum into the 13-bit two's-complement range.
  function automatic logic [ADC_W-1:0] sat13(input logic signed [ADC_W:0] s);
    if (s > 14'sd4095) begin
      return 13'h0FFF;
    end else if (s < -14'sd4096) begin
      return 13'h1000;
    end else begin
      return s[ADC_W-1:0];
    end
  endfunction

  // True when sat13() would have to clamp this sum.
  function automatic logic is_sat13(input logic signed [ADC_W:0] s);
    return (s > 14'sd4095) || (s < -14'sd4096);
  endfunction

endpackage

// File: rtl/font5_base_if.sv
// rtl/font5_base_if.sv - ADC capture words in, DAC words and strobes out
interface font5_base_if;
  import font5_pkg::*;

  logic [ADC_W-1:0] ch1_data_in_del;
  logic [ADC_W-1:0] ch2_data_in_del;
  logic [ADC_W-1:0] ch4_data_in_del;
  logic [ADC_W-1:0] ch5_data_in_del;
  logic [ADC_W-1:0] dac1_out;
  logic             dac1_clk;
  logic [ADC_W-1:0] dac2_out;
  logic             dac2_clk;

  // ADC side drives the raw words and observes the DAC pins.
  modport master (
    output ch1_data_in_del, ch2_data_in_del, ch4_data_in_del, ch5_data_in_del,
    input  dac1_out, dac1_clk, dac2_out, dac2_clk
  );

  // Datapath consumes the raw words and drives the DAC pins.
  modport slave (
    input  ch1_data_in_del, ch2_data_in_del, ch4_data_in_del, ch5_data_in_del,
    output dac1_out, dac1_clk, dac2_out, dac2_clk
  );

endinterface

// File: rtl/font5_fb_pair.sv
// rtl/font5_fb_pair.sv - decode, add and saturate one ADC channel pair into an offset-binary DAC word
module font5_fb_pair
  import font5_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ADC_W-1:0] raw_a,
  input  logic [ADC_W-1:0] raw_b,
  input  logic [ADC_W-1:0] mask_a,
  input  logic [ADC_W-1:0] mask_b,
  output logic [ADC_W-1:0] dac_out,
  output logic             sat
);

  logic [ADC_W-1:0]        raw_a_q, raw_a_d;
  logic [ADC_W-1:0]        raw_b_q, raw_b_d;
  logic signed [ADC_W:0]   sum_q, sum_d;
  logic [ADC_W-1:0]        dac_q, dac_d;
  logic [ADC_W-1:0]        dec_a;
  logic [ADC_W-1:0]        dec_b;

  // Next-state for the three pipeline stages: capture, sum, saturate + offset.
  always_comb begin
    raw_a_d = raw_a;
    raw_b_d = raw_b;
    dec_a   = raw_a_q ^ mask_a;
    dec_b   = raw_b_q ^ mask_b;
    sum_d   = {dec_a[ADC_W-1], dec_a} + {dec_b[ADC_W-1], dec_b};
    // Flipping the MSB converts two's complement to offset binary.
    dac_d   = sat13(sum_q) ^ MIDSCALE;
  end

  // Pipeline registers; reset parks the DAC word at midscale (zero volts).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      raw_a_q <= '0;
      raw_b_q <= '0;
      sum_q   <= '0;
      dac_q   <= MIDSCALE;
    end else begin
      raw_a_q <= raw_a_d;
      raw_b_q <= raw_b_d;
      sum_q   <= sum_d;
      dac_q   <= dac_d;
    end
  end

  // Saturation is flagged in the same cycle the clamped word is registered.
  assign sat     = is_sat13(sum_q);
  assign dac_out = dac_q;

endmodule

// File: rtl/font5_base.sv
// rtl/font5_base.sv - FONT5 feedback top: two channel-pair sums to DACs, trigger, LEDs and ADC power
module font5_base
  import font5_pkg::*;
#(
  parameter int HB_BITS = 26
) (
  input  logic        clk357,
  input  logic        rst_n,
  font5_base_if.slave bus,
  input  logic        diginput1,
  output logic        adc_powerdown,
  output logic        led0_out,
  output logic        led1_out,
  output logic        led2_out
);

  logic [ADC_W-1:0]   dac1;
  logic [ADC_W-1:0]   dac2;
  logic               sat1;
  logic               sat2;

  strobe_state_e      state_q, state_d;
  logic               dac_clk_q, dac_clk_d;
  logic               led1_q, led1_d;
  logic [HB_BITS-1:0] hb_q, hb_d;
  logic               led0_q, led0_d;
  logic               trig_s1_q, trig_s1_d;
  logic               trig_s2_q, trig_s2_d;
  logic               led2_q, led2_d;
  logic               pd_q, pd_d;

  font5_fb_pair u_pair1 (
    .clk     (clk357),
    .rst_n   (rst_n),
    .raw_a   (bus.ch1_data_in_del),
    .raw_b   (bus.ch2_data_in_del),
    .mask_a  (CH1_BITFLIP),
    .mask_b  (CH2_BITFLIP),
    .dac_out (dac1),
    .sat     (sat1)
  );

  font5_fb_pair u_pair2 (
    .clk     (clk357),
    .rst_n   (rst_n),
    .raw_a   (bus.ch4_data_in_del),
    .raw_b   (bus.ch5_data_in_del),
    .mask_a  (CH4_BITFLIP),
    .mask_b  (CH5_BITFLIP),
    .dac_out (dac2),
    .sat     (sat2)
  );

  // Strobe sequencer plus LED, trigger synchroniser and power-down next-state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FLUSH0: state_d = ST_FLUSH1;
      ST_FLUSH1: state_d = ST_FLUSH2;
      ST_FLUSH2: state_d = ST_RUN;
      ST_RUN:    state_d = ST_RUN;
      default:   state_d = ST_FLUSH0;
    endcase
    // Strobe rises together with the first word that went through all three stages.
    dac_clk_d = (state_d == ST_RUN);
    led1_d    = led1_q | sat1 | sat2;
    hb_d      = hb_q + {{(HB_BITS-1){1'b0}}, 1'b1};
    led0_d    = led0_q ^ (&hb_q);
    trig_s1_d = diginput1;
    trig_s2_d = trig_s1_q;
    led2_d    = trig_s2_q;
    pd_d      = 1'b0;
  end

  // State register for all top-level control flops.
  always_ff @(posedge clk357) begin
    if (!rst_n) begin
      state_q   <= ST_FLUSH0;
      dac_clk_q <= 1'b0;
      led1_q    <= 1'b0;
      hb_q      <= '0;
      led0_q    <= 1'b0;
      trig_s1_q <= 1'b0;
      trig_s2_q <= 1'b0;
      led2_q    <= 1'b0;
      pd_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      dac_clk_q <= dac_clk_d;
      led1_q    <= led1_d;
      hb_q      <= hb_d;
      led0_q    <= led0_d;
      trig_s1_q <= trig_s1_d;
      trig_s2_q <= trig_s2_d;
      led2_q    <= led2_d;
      pd_q      <= pd_d;
    end
  end

  assign bus.dac1_out = dac1;
  assign bus.dac2_out = dac2;
  assign bus.dac1_clk = dac_clk_q;
  assign bus.dac2_clk = dac_clk_q;
  assign adc_powerdown = pd_q;
  assign led0_out      = led0_q;
  assign led1_out      = led1_q;
  assign led2_out      = led2_q;

endmodule

// File: tb/tb_font5_base.sv
// tb/tb_font5_base.sv - scoreboard bench for font5_base with directed and random channel stimulus
`timescale 1ns/100ps
module tb_font5_base;
  import font5_pkg::*;

  localparam int HB = 6;

  logic clk357 = 1'b0;
  logic rst_n = 1'b0;
  logic diginput1 = 1'b0;
  logic adc_powerdown, led0_out, led1_out, led2_out;

  font5_base_if bus();

  font5_base #(.HB_BITS(HB)) dut (
    .clk357        (clk357),
    .rst_n         (rst_n),
    .bus           (bus),
    .diginput1     (diginput1),
    .adc_powerdown (adc_powerdown),
    .led0_out      (led0_out),
    .led1_out      (led1_out),
    .led2_out      (led2_out)
  );

  always #1.4 clk357 = ~clk357;

  typedef struct {
    logic [12:0] d1;
    logic [12:0] d2;
    logic        l1;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   sticky = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: plain integer add, clamp, then shift into offset binary.
  function automatic logic [12:0] ref_dac(input int a, input int b);
    int s;
    s = a + b;
    if (s > 4095) s = 4095;
    if (s < -4096) s = -4096;
    return 13'(s + 4096);
  endfunction

  function automatic bit ref_ovf(input int a, input int b);
    return (a + b > 4095) || (a + b < -4096);
  endfunction

  // One stimulus cycle, applied at the falling edge.
  task automatic step(input bit r, input int c1, input int c2, input int c4, input int c5, input bit trig);
    exp_t e;
    @(negedge clk357);
    rst_n = r;
    bus.ch1_data_in_del = 13'(c1) ^ CH1_BITFLIP;
    bus.ch2_data_in_del = 13'(c2) ^ CH2_BITFLIP;
    bus.ch4_data_in_del = 13'(c4) ^ CH4_BITFLIP;
    bus.ch5_data_in_del = 13'(c5) ^ CH5_BITFLIP;
    diginput1 = trig;
    if (!r) begin
      sb_q.delete();
      sticky = 1'b0;
    end else begin
      sticky = sticky | ref_ovf(c1, c2) | ref_ovf(c4, c5);
      e.d1 = ref_dac(c1, c2);
      e.d2 = ref_dac(c4, c5);
      e.l1 = sticky;
      sb_q.push_back(e);
    end
  endtask

  // Monitor: checks control outputs every edge and pops the scoreboard on each DAC strobe.
  initial begin
    int   hb;
    bit   p1, p2, r, dg;
    exp_t e;
    hb = 0; p1 = 1'b0; p2 = 1'b0;
    forever begin
      @(posedge clk357);
      r  = rst_n;
      dg = diginput1;
      #0.2;
      if (!r) begin
        hb = 0; p1 = 1'b0; p2 = 1'b0;
        check("rst_dac1_out", bus.dac1_out, 13'h1000);
        check("rst_dac2_out", bus.dac2_out, 13'h1000);
        check("rst_dac_clk", {bus.dac1_clk, bus.dac2_clk}, 2'b00);
        check("rst_powerdown", adc_powerdown, 1'b1);
        check("rst_leds", {led0_out, led1_out, led2_out}, 3'b000);
      end else begin
        hb++;
        check("adc_powerdown", adc_powerdown, 1'b0);
        check("dac1_clk", bus.dac1_clk, (hb >= 3));
        check("dac2_clk", bus.dac2_clk, (hb >= 3));
        check("led0_heartbeat", led0_out, (hb >> HB) & 1);
        check("led2_trigger", led2_out, p2);
        p2 = p1;
        p1 = dg;
        if (bus.dac1_clk) begin
          if (sb_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("dac1_out", bus.dac1_out, e.d1);
            check("dac2_out", bus.dac2_out, e.d2);
            check("led1_sticky", led1_out, e.l1);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Directed scenarios, then randomized traffic with occasional resets.
  initial begin
    int hi_cnt, first_hi;
    bus.ch1_data_in_del = '0;
    bus.ch2_data_in_del = '0;
    bus.ch4_data_in_del = '0;
    bus.ch5_data_in_del = '0;

    repeat (10) step(0, 0, 0, 0, 0, 0);
    check("dir_reset_dac1", bus.dac1_out, 13'h1000);
    check("dir_reset_dac2", bus.dac2_out, 13'h1000);
    check("dir_reset_clk", bus.dac1_clk, 1'b0);
    check("dir_reset_pd", adc_powerdown, 1'b1);

    repeat (6) step(1, 1000, -128, 500, 63, 0);
    check("dir_sum_dac1", bus.dac1_out, 13'h1368);
    check("dir_sum_dac2", bus.dac2_out, 13'h1233);
    repeat (153) step(1, 0, 0, 0, 0, 0);
    check("dir_zero_dac1", bus.dac1_out, 13'h1000);
    check("dir_zero_dac2", bus.dac2_out, 13'h1000);

    repeat (5) step(1, 4095, 0, -4096, 0, 0);
    check("dir_edge_dac1", bus.dac1_out, 13'h1FFF);
    check("dir_edge_dac2", bus.dac2_out, 13'h0000);
    check("dir_edge_led1", led1_out, 1'b0);

    repeat (5) step(1, 4000, 4000, 0, 0, 0);
    check("dir_pos_ovf_dac1", bus.dac1_out, 13'h1FFF);
    check("dir_pos_ovf_led1", led1_out, 1'b1);
    repeat (5) step(1, 0, 0, 0, 0, 0);
    check("dir_led1_held", led1_out, 1'b1);

    repeat (5) step(1, 0, 0, -4096, -1, 0);
    check("dir_neg_ovf_dac2", bus.dac2_out, 13'h0000);

    hi_cnt = 0; first_hi = -1;
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0, 0, 0, (i < 5));
      if (led2_out) begin
        hi_cnt++;
        if (first_hi < 0) first_hi = i;
      end
    end
    check("dir_trig_width", hi_cnt, 5);
    check("dir_trig_delay", first_hi, 3);

    repeat (6) step(1, 1000, -128, 0, 0, 0);
    check("dir_mid_pre", bus.dac1_out, 13'h1368);
    step(0, 1000, -128, 0, 0, 0);
    step(0, 1000, -128, 0, 0, 0);
    check("dir_mid_rst_dac1", bus.dac1_out, 13'h1000);
    check("dir_mid_rst_clk", bus.dac1_clk, 1'b0);
    step(1, 1000, -128, 0, 0, 0);
    step(1, 1000, -128, 0, 0, 0);
    check("dir_rel_clk_e1", bus.dac1_clk, 1'b0);
    step(1, 1000, -128, 0, 0, 0);
    check("dir_rel_clk_e2", bus.dac1_clk, 1'b0);
    step(1, 1000, -128, 0, 0, 0);
    check("dir_rel_clk_e3", bus.dac1_clk, 1'b1);
    check("dir_rel_dac1", bus.dac1_out, 13'h1368);

    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 149) != 0),
           int'($urandom_range(0, 8191)) - 4096,
           int'($urandom_range(0, 8191)) - 4096,
           int'($urandom_range(0, 8191)) - 4096,
           int'($urandom_range(0, 8191)) - 4096,
           $urandom_range(0, 1));
    end
    repeat (4) step(1, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
